// File: rtl/uart_rx.sv
// 16x-oversampling UART receiver with runtime frame format.
// Companion to the configurable UART transmitter; shares s_tick.
module uart_rx #(
  parameter int SYNC_STAGES = 2
) (
  input  logic       clk,
  input  logic       reset_n,
  input  logic       s_tick,
  input  logic       rx,
  input  logic [2:0] dbit_select_i,
  input  logic [1:0] sbit_select_i,
  input  logic [1:0] parity_select_i,
  output logic [7:0] rx_dout,
  output logic       rx_done_tick,
  output logic       parity_err,
  output logic       frame_err
);

  typedef enum logic [2:0] {
    IDLE, START, DATA, PARITY, STOP
  } state_t;

  state_t                 state;
  logic [SYNC_STAGES-1:0] sync_q;
  logic                   rxs;
  logic [4:0]             s;
  logic [2:0]             n;
  logic [7:0]             b;
  logic [1:0]             dsel_q;
  logic [1:0]             sbit_q;
  logic                   par_en_q;
  logic                   par_odd_q;
  logic                   pbit_q;
  logic                   stop_q;

  logic [2:0] last_n;
  logic [1:0] shamt;
  logic [7:0] data_al;
  logic       par_calc;
  logic [4:0] stop_term;
  logic       stop_now;

  assign rxs = sync_q[SYNC_STAGES-1];

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) sync_q <= '1;
    else          sync_q <= {sync_q[SYNC_STAGES-2:0], rx};
  end

  // dbits-1 is 4..7, i.e. {1, dsel}; right-align by 8-dbits
  always_comb begin
    last_n   = {1'b1, dsel_q};
    shamt    = 2'd3 - dsel_q;
    data_al  = b >> shamt;
    par_calc = (^data_al) ^ par_odd_q;
    stop_now = (s == 5'd15) ? rxs : stop_q;
    stop_term = 5'd31;
    unique case (1'b1)
      (sbit_q == 2'b00): stop_term = 5'd15;
      (sbit_q == 2'b01): stop_term = 5'd23;
      default:           stop_term = 5'd31;
    endcase
  end

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      state        <= IDLE;
      s            <= '0;
      n            <= '0;
      b            <= '0;
      dsel_q       <= '0;
      sbit_q       <= '0;
      par_en_q     <= 1'b0;
      par_odd_q    <= 1'b0;
      pbit_q       <= 1'b0;
      stop_q       <= 1'b0;
      rx_dout      <= '0;
      rx_done_tick <= 1'b0;
      parity_err   <= 1'b0;
      frame_err    <= 1'b0;
    end else begin
      rx_done_tick <= 1'b0;
      unique case (state)
        IDLE: begin
          dsel_q    <= dbit_select_i[2] ? 2'b11
                                        : dbit_select_i[1:0];
          sbit_q    <= sbit_select_i;
          par_en_q  <= (parity_select_i == 2'b01) ||
                       (parity_select_i == 2'b10);
          par_odd_q <= (parity_select_i == 2'b10);
          if (!rxs) begin
            state <= START;
            s     <= '0;
          end
        end
        START: if (s_tick) begin
          if (s == 5'd7) begin
            if (!rxs) begin
              state <= DATA;
              s     <= '0;
              n     <= '0;
            end else begin
              state <= IDLE;
            end
          end else begin
            s <= s + 5'd1;
          end
        end
        DATA: if (s_tick) begin
          if (s == 5'd15) begin
            s <= '0;
            b <= {rxs, b[7:1]};
            if (n == last_n)
              state <= par_en_q ? PARITY : STOP;
            else
              n <= n + 3'd1;
          end else begin
            s <= s + 5'd1;
          end
        end
        PARITY: if (s_tick) begin
          if (s == 5'd15) begin
            pbit_q <= rxs;
            s      <= '0;
            state  <= STOP;
          end else begin
            s <= s + 5'd1;
          end
        end
        STOP: if (s_tick) begin
          if (s == 5'd15) stop_q <= rxs;
          if (s == stop_term) begin
            rx_dout      <= data_al;
            parity_err   <= par_en_q & (pbit_q != par_calc);
            frame_err    <= ~stop_now;
            rx_done_tick <= 1'b1;
            state        <= IDLE;
          end else begin
            s <= s + 5'd1;
          end
        end
        default: state <= IDLE;
      endcase
    end
  end

endmodule
